// File: rtl/otf_converter_hd.sv
// otf_converter_hd: converts an MSD-first signed-digit stream into a two's-complement word using Q/QM on-the-fly conversion.
// Optional feature macro OTF_SKIP_EN: the first SKIP digits of each frame are accepted and then discarded.
module otf_converter_hd #(
  parameter int DIGITS = 20,
  parameter int SKIP   = 3
) (
  input  logic              clk,
  input  logic              asyn_reset,
  input  logic [1:0]        digit_in,
  input  logic              digit_in_vld,
  output logic              digit_in_rdy,
  output logic [DIGITS:0]   word_out,
  output logic              word_out_vld,
  input  logic              word_out_rdy
);

  localparam int CNT_W = $clog2(DIGITS + SKIP + 1);
`ifdef OTF_SKIP_EN
  localparam int FRAME_LEN = DIGITS + SKIP;
`else
  localparam int FRAME_LEN = DIGITS;
`endif

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [DIGITS:0]  q_r;
  logic [DIGITS:0]  qm_r;
  logic [DIGITS:0]  q_nxt_s;
  logic [DIGITS:0]  qm_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             accept_s;
  logic             last_s;
  logic             skip_s;
  logic             pos_s;
  logic             neg_s;

  // Digit decode; code 11 decodes as neither +1 nor -1, i.e. zero
  assign pos_s    = digit_in[1] & ~digit_in[0];
  assign neg_s    = ~digit_in[1] & digit_in[0];
  assign accept_s = (state_r == COLLECT) && digit_in_vld;
  assign last_s   = (cnt_r == CNT_W'(FRAME_LEN - 1));
  assign word_out = q_r;

`ifdef OTF_SKIP_EN
  assign skip_s = (cnt_r < CNT_W'(SKIP));
`else
  assign skip_s = 1'b0;
`endif

  // Next-state, conversion register and digit counter update
  always_comb begin
    state_nxt_s = state_r;
    q_nxt_s     = q_r;
    qm_nxt_s    = qm_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        state_nxt_s = COLLECT;
        q_nxt_s     = {(DIGITS+1){1'b0}};
        qm_nxt_s    = {(DIGITS+1){1'b1}};
        cnt_nxt_s   = {CNT_W{1'b0}};
      end
      COLLECT: begin
        if (accept_s) begin
          cnt_nxt_s = cnt_r + CNT_W'(1'b1);
          if (skip_s) begin
            q_nxt_s  = q_r;
            qm_nxt_s = qm_r;
          end else if (pos_s) begin
            q_nxt_s  = {q_r[DIGITS-1:0], 1'b1};
            qm_nxt_s = {q_r[DIGITS-1:0], 1'b0};
          end else if (neg_s) begin
            q_nxt_s  = {qm_r[DIGITS-1:0], 1'b1};
            qm_nxt_s = {qm_r[DIGITS-1:0], 1'b0};
          end else begin
            q_nxt_s  = {q_r[DIGITS-1:0], 1'b0};
            qm_nxt_s = {qm_r[DIGITS-1:0], 1'b1};
          end
          if (last_s) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = COLLECT;
          end
        end else begin
          state_nxt_s = COLLECT;
        end
      end
      DONE: begin
        if (word_out_rdy) begin
          state_nxt_s = COLLECT;
          q_nxt_s     = {(DIGITS+1){1'b0}};
          qm_nxt_s    = {(DIGITS+1){1'b1}};
          cnt_nxt_s   = {CNT_W{1'b0}};
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        q_nxt_s     = {(DIGITS+1){1'b0}};
        qm_nxt_s    = {(DIGITS+1){1'b1}};
        cnt_nxt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State registers; handshake outputs are registered from the next state
  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      state_r      <= IDLE;
      q_r          <= {(DIGITS+1){1'b0}};
      qm_r         <= {(DIGITS+1){1'b1}};
      cnt_r        <= {CNT_W{1'b0}};
      digit_in_rdy <= 1'b0;
      word_out_vld <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      q_r          <= q_nxt_s;
      qm_r         <= qm_nxt_s;
      cnt_r        <= cnt_nxt_s;
      digit_in_rdy <= (state_nxt_s == COLLECT);
      word_out_vld <= (state_nxt_s == DONE);
    end
  end

endmodule

// File: tb/tb_otf_converter_hd.sv
// Directed, table-driven bench for otf_converter_hd with DIGITS=4, SKIP=2.
// Under OTF_SKIP_EN every frame is prefixed with SKIP discarded digits (-1, +1, ...).
module tb_otf_converter_hd;

  localparam int DIGITS = 4;
  localparam int SKIP   = 2;
`ifdef OTF_SKIP_EN
  localparam int NSKIP = SKIP;
`else
  localparam int NSKIP = 0;
`endif

  typedef struct {
    string        name;
    logic [7:0]   digs;   // four 2-bit codes, first digit in [7:6]
    logic [4:0]   exp;
  } vec_t;

  logic         clk = 1'b0;
  logic         asyn_reset = 1'b1;
  logic [1:0]   digit_in = 2'b00;
  logic         digit_in_vld = 1'b0;
  logic         digit_in_rdy;
  logic [4:0]   word_out;
  logic         word_out_vld;
  logic         word_out_rdy = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  vec_t vecs[6];

  otf_converter_hd #(.DIGITS(DIGITS), .SKIP(SKIP)) dut (
    .clk          (clk),
    .asyn_reset   (asyn_reset),
    .digit_in     (digit_in),
    .digit_in_vld (digit_in_vld),
    .digit_in_rdy (digit_in_rdy),
    .word_out     (word_out),
    .word_out_vld (word_out_vld),
    .word_out_rdy (word_out_rdy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; waits (bounded) for digit_in_rdy, then transfers one digit.
  task automatic send_digit(input logic [1:0] d);
    int k = 0;
    while (!digit_in_rdy && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("rdy_wait", {31'd0, digit_in_rdy}, 32'd1);
    digit_in     = d;
    digit_in_vld = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_skip();
    for (int s = 0; s < NSKIP; s++) begin
      send_digit((s % 2 == 0) ? 2'b01 : 2'b10);
    end
  endtask

  task automatic send_frame(input string name, input logic [7:0] digs, input logic [4:0] exp);
    send_skip();
    for (int i = 0; i < 4; i++) begin
      send_digit(digs[7-2*i -: 2]);
      if (i < 3) check({name, "_vld_early"}, {31'd0, word_out_vld}, 32'd0);
    end
    digit_in_vld = 1'b0;
    check({name, "_vld_latency"}, {31'd0, word_out_vld}, 32'd1);
    check({name, "_word"}, {27'd0, word_out}, {27'd0, exp});
  endtask

  task automatic accept_word(input string name);
    word_out_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    word_out_rdy = 1'b0;
    check({name, "_rdy_after_hs"}, {31'd0, digit_in_rdy}, 32'd1);
    check({name, "_vld_after_hs"}, {31'd0, word_out_vld}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{"pos_mix",  8'b10_00_01_10, 5'b00111};
    vecs[1] = '{"all_neg",  8'b01_01_01_01, 5'b10001};
    vecs[2] = '{"code11",   8'b10_01_11_00, 5'b00100};
    vecs[3] = '{"lsb_only", 8'b00_00_00_10, 5'b00001};
    vecs[4] = '{"neg_pos",  8'b01_10_00_00, 5'b11100};
    vecs[5] = '{"mid_neg",  8'b00_10_00_01, 5'b00011};

    // Reset values and the first-ready timing
    @(negedge clk);
    check("rst_rdy",  {31'd0, digit_in_rdy}, 32'd0);
    check("rst_vld",  {31'd0, word_out_vld}, 32'd0);
    check("rst_word", {27'd0, word_out}, 32'd0);
    asyn_reset = 1'b0;
    check("rdy_first_cycle", {31'd0, digit_in_rdy}, 32'd0);
    @(negedge clk);
    check("rdy_second_cycle", {31'd0, digit_in_rdy}, 32'd1);

    for (int v = 0; v < 6; v++) begin
      send_frame(vecs[v].name, vecs[v].digs, vecs[v].exp);
      accept_word(vecs[v].name);
    end

    // Consumer stalls for 5 cycles while the producer keeps offering +1
    send_frame("hold_pre", 8'b10_00_01_10, 5'b00111);
    digit_in     = 2'b10;
    digit_in_vld = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_word", {27'd0, word_out}, 32'd7);
      check("hold_vld",  {31'd0, word_out_vld}, 32'd1);
      check("hold_rdy",  {31'd0, digit_in_rdy}, 32'd0);
    end
    digit_in_vld = 1'b0;
    accept_word("hold");
    send_frame("hold_post", 8'b00_00_00_10, 5'b00001);
    accept_word("hold_post");

    // Producer valid toggles every other cycle
    send_skip();
    for (int i = 0; i < 4; i++) begin
      send_digit(2'b10);
      if (i < 3) begin
        digit_in_vld = 1'b0;
        check("gap_vld", {31'd0, word_out_vld}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("gap_rdy", {31'd0, digit_in_rdy}, 32'd1);
      end
    end
    digit_in_vld = 1'b0;
    check("gap_done_vld", {31'd0, word_out_vld}, 32'd1);
    check("gap_word", {27'd0, word_out}, 32'd15);
    accept_word("gap");

    // Reset in the middle of a frame
    send_skip();
    send_digit(2'b10);
    send_digit(2'b10);
    digit_in_vld = 1'b0;
    check("mid_rst_pre_word", {27'd0, word_out}, 32'd3);
    asyn_reset = 1'b1;
    #1;
    check("mid_rst_word", {27'd0, word_out}, 32'd0);
    check("mid_rst_rdy",  {31'd0, digit_in_rdy}, 32'd0);
    check("mid_rst_vld",  {31'd0, word_out_vld}, 32'd0);
    @(negedge clk);
    asyn_reset = 1'b0;
    send_frame("post_rst", 8'b00_00_00_10, 5'b00001);
    accept_word("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/otf_converter_hd.md
# otf_converter_hd

Digit-serial sink for the online arithmetic datapath. Consumes the most-significant-digit-first signed-digit stream produced by `Multiplier_hd` (`p_value` plus its valid/ready pair). Converts each frame to a conventional two's-complement word by on-the-fly conversion, with no carry-propagate adder. Sits between the online multiplier/divider outputs and any conventional-binary consumer.

## Interface
- `DIGITS`, 20: digits per frame that are accumulated into the word.
- `SKIP`, 3: leading digits discarded per frame; only used when `OTF_SKIP_EN` is defined.
- `clk`  in  1  single clock, all state on rising edge.
- `asyn_reset`  in  1  reset, asynchronous and active-high.
- `digit_in`  in  2  signed digit; value = `digit_in[1]` − `digit_in[0]`, so 10=+1, 01=−1, 00=0, 11=0.
- `digit_in_vld`  in  1  producer has a digit.
- `digit_in_rdy`  out  1  block accepts a digit; a transfer occurs when `vld && rdy` at a rising edge.
- `word_out`  out  DIGITS+1  two's-complement integer value of the frame.
- `word_out_vld`  out  1  `word_out` is valid.
- `word_out_rdy`  in  1  consumer accepts the word.

## Operation
- Frame value: W = Σ d_i·2^(DIGITS−i), for i = 1..DIGITS, with d_1 first. The range is ±(2^DIGITS − 1), which always fits in DIGITS+1 bits, so no overflow is possible.
- Registers:
  - Q, QM, both DIGITS+1 bits.
  - Invariant QM = Q − 1, modulo 2^(DIGITS+1).
  - Frame start: Q = 0, QM = all ones.
- Update per accepted digit d, shifting left by 1 within DIGITS+1 bits (MSB drops):
  - d = +1: Q ← {Q,1}, QM ← {Q,0}.
  - d = 0: Q ← {Q,0}, QM ← {QM,1}.
  - d = −1: Q ← {QM,1}, QM ← {QM,0}.
- `word_out` = Q.
- Digit counter: width clog2(DIGITS+SKIP+1). Cleared at frame start, incremented on every accepted digit, including skipped ones.
- FSM:
  - IDLE → COLLECT unconditionally on the next edge.
  - COLLECT → DONE on acceptance of the final digit of the frame.
  - DONE → COLLECT on `word_out_vld && word_out_rdy`. In the same edge, Q, QM and the counter are reinitialised.
- Outputs by state:
  - `digit_in_rdy` = 1 only in COLLECT.
  - `word_out_vld` = 1 only in DONE.
- Digit code 11 is accepted and processed as 0.

## Timing
- Reset values while `asyn_reset` = 1:
  - state IDLE, `digit_in_rdy` = 0, `word_out_vld` = 0, `word_out` = 0.
  - QM all ones, counter 0.
- First `digit_in_rdy` = 1 appears in the second cycle after reset release.
- Throughput: one digit per cycle in COLLECT.
- Latency: the final digit accepted at edge k gives `word_out_vld` = 1 from edge k onward, i.e. visible in cycle k+1.
- In DONE:
  - `word_out` is stable and `digit_in_rdy` = 0 for as long as `word_out_rdy` is low.
  - Upstream digits presented during DONE are not consumed.
- After the word handshake, `digit_in_rdy` returns to 1 in the next cycle. Minimum frame period is DIGITS(+SKIP)+1 cycles.
- Reset asserted mid-frame or in DONE: partial frame and any pending word are discarded immediately, and outputs take their reset values asynchronously.
- `digit_in_vld` low in COLLECT: state, Q, QM and counter hold.

## Configuration
- `OTF_SKIP_EN` defined:
  - The first SKIP accepted digits of each frame are handshaken but do not update Q/QM.
  - A frame is SKIP+DIGITS digits long.
  - This absorbs the online delay of the upstream operator.
- `OTF_SKIP_EN` undefined: `SKIP` is ignored and a frame is exactly DIGITS digits.

## Test plan
- DIGITS=4, digits +1,0,−1,+1 → `word_out` = 00111 (7); vld rises the cycle after the 4th transfer.
- DIGITS=4, digits −1,−1,−1,−1 → 10001 (−15); then digits +1,−1,11,00 → 00100 (4), checking that code 11 is treated as 0.
- Hold `word_out_rdy` low for 5 cycles after a word → `word_out` and `word_out_vld` stable, `digit_in_rdy` = 0 throughout, no digit consumed; a 6th-cycle accept lets the next frame start.
- Toggle `digit_in_vld` every other cycle with DIGITS=4, digits +1,+1,+1,+1 → 01111 (15) after 8 cycles.
- Assert `asyn_reset` after 2 digits (+1,+1) → outputs 0 immediately; the next frame of 0,0,0,+1 gives 00001.
- `OTF_SKIP_EN`, SKIP=2, DIGITS=4, digits −1,+1 (discarded) then +1,0,−1,+1 → 00111; `word_out_vld` follows the 6th transfer.
